mem_bus_arbiter: RTL and testbench

- Two-master, one-slave AHB-Lite arbiter that shares the single-port data/instruction RAM between the LSU data bus (master 0) and the instruction fetch bus (master 1).
- Each master port has a 1-entry address-phase buffer. A master that loses arbitration is accepted, then stalled in its data phase, so no master ever sees a false completion.
- Uncontested transfers pass through with zero added latency.

---
 rtl/mem_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master AHB-Lite arbiter in front of the shared single-port RAM.
// A master that loses arbitration is buffered and stalled in its data phase.
module mem_bus_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [1:0]    m0_htrans,
    input  logic          m0_hwrite,
    input  logic [2:0]    m0_hsize,
    input  logic [AW-1:0] m0_haddr,
    input  logic [DW-1:0] m0_hwdata,
    output logic          m0_hready,
    output logic          m0_hresp,
    output logic [DW-1:0] m0_hrdata,
    input  logic [1:0]    m1_htrans,
    input  logic          m1_hwrite,
    input  logic [2:0]    m1_hsize,
    input  logic [AW-1:0] m1_haddr,
    input  logic [DW-1:0] m1_hwdata,
    output logic          m1_hready,
    output logic          m1_hresp,
    output logic [DW-1:0] m1_hrdata,
    output logic [1:0]    s_htrans,
    output logic          s_hwrite,
    output logic [2:0]    s_hsize,
    output logic [AW-1:0] s_haddr,
    output logic [DW-1:0] s_hwdata,
    input  logic          s_hready,
    input  logic          s_hresp,
    input  logic [DW-1:0] s_hrdata
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    owner_t        r_downer;
    logic          r_last_grant;
    logic [1:0]    r_pend_v;
    logic [1:0]    r_pend_write;
    logic [2:0]    r_pend_size [2];
    logic [AW-1:0] r_pend_addr [2];

    logic [1:0]    w_stall;
    logic [1:0]    w_live;
    logic [1:0]    w_cand;
    logic          w_issue;
    logic          w_win;
    logic [1:0]    w_in_write;
    logic [2:0]    w_in_size [2];
    logic [AW-1:0] w_in_addr [2];
    logic          w_sel_write;
    logic [2:0]    w_sel_size;
    logic [AW-1:0] w_sel_addr;
    logic          w_unused;

    assign w_unused = ^{m0_htrans[0], m1_htrans[0]};

    assign w_in_write   = {m1_hwrite, m0_hwrite};
    assign w_in_size[0] = m0_hsize;
    assign w_in_size[1] = m1_hsize;
    assign w_in_addr[0] = m0_haddr;
    assign w_in_addr[1] = m1_haddr;

    assign w_stall[0] = (r_downer == OWN_M0) & ~s_hready;
    assign w_stall[1] = (r_downer == OWN_M1) & ~s_hready;
    assign m0_hready  = ~r_pend_v[0] & ~w_stall[0];
    assign m1_hready  = ~r_pend_v[1] & ~w_stall[1];

    assign w_live[0] = m0_htrans[1] & m0_hready;
    assign w_live[1] = m1_htrans[1] & m1_hready;
    assign w_cand    = r_pend_v | w_live;
    assign w_issue   = s_hready & (|w_cand);

    // Pick the winner: master 0 under fixed priority, else alternate on a tie
    always_comb begin
        w_win = w_cand[1];
        if (w_cand == 2'b11) begin
            w_win = FIXED_PRIO ? 1'b0 : ~r_last_grant;
        end
    end

    // Winner's address phase comes from its buffer when one is held
    always_comb begin
        w_sel_write = w_in_write[w_win];
        w_sel_size  = w_in_size[w_win];
        w_sel_addr  = w_in_addr[w_win];
        if (r_pend_v[w_win]) begin
            w_sel_write = r_pend_write[w_win];
            w_sel_size  = r_pend_size[w_win];
            w_sel_addr  = r_pend_addr[w_win];
        end
    end

    assign s_htrans = w_issue ? 2'b10 : 2'b00;
    assign s_hwrite = w_issue & w_sel_write;
    assign s_hsize  = w_issue ? w_sel_size : 3'b000;
    assign s_haddr  = w_issue ? w_sel_addr : '0;

    // Write data follows whichever master owns the slave data phase
    always_comb begin
        s_hwdata = '0;
        case (r_downer)
            OWN_M0:  s_hwdata = m0_hwdata;
            OWN_M1:  s_hwdata = m1_hwdata;
            default: s_hwdata = '0;
        endcase
    end

    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;
    assign m0_hresp  = s_hresp & (r_downer == OWN_M0);
    assign m1_hresp  = s_hresp & (r_downer == OWN_M1);

    // Data-phase owner and round-robin pointer
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_downer     <= OWN_NONE;
            r_last_grant <= 1'b1;
        end else if (w_issue) begin
            r_downer     <= w_win ? OWN_M1 : OWN_M0;
            r_last_grant <= w_win;
        end else if (s_hready) begin
            r_downer     <= OWN_NONE;
        end
    end

    // Buffers fill on an accepted but unissued request, drain on issue
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_pend_v     <= 2'b00;
            r_pend_write <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_pend_size[i] <= 3'b000;
                r_pend_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_issue && (w_win == 1'(i))) begin
                    r_pend_v[i] <= 1'b0;
                end else if (w_live[i]) begin
                    r_pend_v[i]     <= 1'b1;
                    r_pend_write[i] <= w_in_write[i];
                    r_pend_size[i]  <= w_in_size[i];
                    r_pend_addr[i]  <= w_in_addr[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vectors, scoreboard queues and a
// negedge monitor that checks every slave address and data phase.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize, m1_hsize;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
    wire         m0_hready, m1_hready, m0_hresp, m1_hresp;
    wire  [31:0] m0_hrdata, m1_hrdata;
    wire  [1:0]  s_htrans;
    wire         s_hwrite;
    wire  [2:0]  s_hsize;
    wire  [31:0] s_haddr, s_hwdata;
    logic        s_hready, s_hresp;
    logic [31:0] s_hrdata;

    logic [1:0]  f_m0_htrans, f_m1_htrans;
    logic [31:0] f_m0_haddr, f_m1_haddr;
    wire         f_m0_hready, f_m1_hready, f_m0_hresp, f_m1_hresp;
    wire  [31:0] f_m0_hrdata, f_m1_hrdata;
    wire  [1:0]  f_s_htrans;
    wire         f_s_hwrite;
    wire  [2:0]  f_s_hsize;
    wire  [31:0] f_s_haddr, f_s_hwdata;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        int          mst;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        resp;
    } rec_t;

    rec_t aq[$];
    rec_t dq[$];

    mem_bus_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1'b0)) u_dut (
        .clk(clk), .rst_b(rst_b),
        .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
        .m0_haddr(m0_haddr), .m0_hwdata(m0_hwdata), .m0_hready(m0_hready),
        .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
        .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
        .m1_haddr(m1_haddr), .m1_hwdata(m1_hwdata), .m1_hready(m1_hready),
        .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
        .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_haddr(s_haddr), .s_hwdata(s_hwdata), .s_hready(s_hready),
        .s_hresp(s_hresp), .s_hrdata(s_hrdata)
    );

    mem_bus_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1'b1)) u_fix (
        .clk(clk), .rst_b(rst_b),
        .m0_htrans(f_m0_htrans), .m0_hwrite(1'b0), .m0_hsize(3'b010),
        .m0_haddr(f_m0_haddr), .m0_hwdata(32'h0), .m0_hready(f_m0_hready),
        .m0_hresp(f_m0_hresp), .m0_hrdata(f_m0_hrdata),
        .m1_htrans(f_m1_htrans), .m1_hwrite(1'b0), .m1_hsize(3'b010),
        .m1_haddr(f_m1_haddr), .m1_hwdata(32'h0), .m1_hready(f_m1_hready),
        .m1_hresp(f_m1_hresp), .m1_hrdata(f_m1_hrdata),
        .s_htrans(f_s_htrans), .s_hwrite(f_s_hwrite), .s_hsize(f_s_hsize),
        .s_haddr(f_s_haddr), .s_hwdata(f_s_hwdata), .s_hready(s_hready),
        .s_hresp(s_hresp), .s_hrdata(s_hrdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [31:0] RR_M0 [8] = '{32'h1000, 32'h1004, 32'h1008, 32'h1008,
                                          32'h100C, 32'h100C, 32'h0, 32'h0};
    localparam logic [31:0] RR_M1 [8] = '{32'h2000, 32'h2004, 32'h2004, 32'h2008,
                                          32'h2008, 32'h0, 32'h0, 32'h0};
    localparam logic [31:0] RR_EX [8] = '{32'h1000, 32'h2000, 32'h1004, 32'h2004,
                                          32'h1008, 32'h2008, 32'h100C, 32'h0};
    localparam logic [7:0]  RR_MST = 8'b0010_1010;
    localparam logic [31:0] F_M0 [6] = '{32'h1000, 32'h1004, 32'h1008, 32'h0, 32'h0, 32'h0};
    localparam logic [31:0] F_M1 [6] = '{32'h2000, 32'h2004, 32'h2004, 32'h2004, 32'h2004, 32'h0};
    localparam logic [31:0] F_EX [6] = '{32'h1000, 32'h1004, 32'h1008, 32'h2000, 32'h2004, 32'h0};
    localparam logic [5:0]  F_HR1 = 6'b110001;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drv(input int m, input logic [31:0] a, input logic w);
        if (m == 0) begin
            m0_htrans = (a != 0) ? 2'b10 : 2'b00;
            m0_haddr = a; m0_hwrite = w; m0_hsize = 3'b010;
        end else begin
            m1_htrans = (a != 0) ? 2'b10 : 2'b00;
            m1_haddr = a; m1_hwrite = w; m1_hsize = 3'b010;
        end
    endtask

    task automatic fdrv(input logic [31:0] a0, input logic [31:0] a1);
        f_m0_htrans = (a0 != 0) ? 2'b10 : 2'b00; f_m0_haddr = a0;
        f_m1_htrans = (a1 != 0) ? 2'b10 : 2'b00; f_m1_haddr = a1;
    endtask

    task automatic exp_x(input int ac, input int dc, input int mst,
                         input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic resp, input bit with_data);
        rec_t r;
        r.cyc = ac; r.mst = mst; r.addr = addr; r.wr = wr;
        r.wdata = wdata; r.rdata = rdata; r.resp = resp;
        aq.push_back(r);
        if (with_data) begin
            r.cyc = dc;
            dq.push_back(r);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        drv(0, 32'h0, 1'b0); drv(1, 32'h0, 1'b0);
        fdrv(32'h0, 32'h0);
        m0_hwdata = '0; m1_hwdata = '0;
        s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
        #1;
        chk("rst_m0_hready", m0_hready, 1);
        chk("rst_m1_hready", m1_hready, 1);
        chk("rst_s_htrans", s_htrans, 0);
        chk("rst_hresp", {m0_hresp, m1_hresp}, 0);
        nxt(); nxt();
        rst_b = 1'b1;
    endtask

    // Monitor: checks each slave data-phase completion, then each address phase
    initial begin : monitor
        rec_t r;
        bit   dp;
        dp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                dp = 1'b0;
            end else begin
                if (dp && s_hready) begin
                    if (dq.size() == 0) begin
                        chk("unexpected_dphase", 1, 0);
                    end else begin
                        r = dq.pop_front();
                        chk("dp_cycle", cyc, r.cyc);
                        if (r.wr) chk("dp_hwdata", s_hwdata, r.wdata);
                        else chk("dp_hrdata", (r.mst == 1) ? m1_hrdata : m0_hrdata, r.rdata);
                        chk("dp_hready", (r.mst == 1) ? m1_hready : m0_hready, 1);
                        chk("dp_hresp", (r.mst == 1) ? m1_hresp : m0_hresp, r.resp);
                        chk("dp_other_hresp", (r.mst == 1) ? m0_hresp : m1_hresp, 0);
                    end
                    dp = 1'b0;
                end
                if (s_htrans[1]) begin
                    if (aq.size() == 0) begin
                        chk("unexpected_issue", s_htrans, 0);
                    end else begin
                        r = aq.pop_front();
                        chk("ap_cycle", cyc, r.cyc);
                        chk("ap_haddr", s_haddr, r.addr);
                        chk("ap_hwrite", s_hwrite, r.wr);
                        chk("ap_hsize", s_hsize, 3'b010);
                    end
                    if (s_hready) dp = 1'b1;
                end
            end
        end
    end

    initial begin : stim
        int c;
        #1;
        do_reset();

        // Single uncontested m0 read
        c = cyc;
        drv(0, 32'h100, 1'b0);
        exp_x(c, c + 1, 0, 32'h100, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1);
        @(negedge clk); chk("t1_m1_hready", m1_hready, 1);
        nxt(); drv(0, 32'h0, 1'b0); s_hrdata = 32'hDEADBEEF;
        @(negedge clk); chk("t1_m1_hready_dp", m1_hready, 1);
        nxt(); s_hrdata = '0;

        // Simultaneous m0 write and m1 read after reset
        do_reset();
        c = cyc;
        drv(0, 32'h200, 1'b1); drv(1, 32'h300, 1'b0);
        exp_x(c, c + 1, 0, 32'h200, 1'b1, 32'h11223344, 0, 1'b0, 1);
        exp_x(c + 1, c + 2, 1, 32'h300, 1'b0, 0, 32'hCAFE0001, 1'b0, 1);
        @(negedge clk);
        chk("t2_m0_hready", m0_hready, 1);
        chk("t2_m1_hready_acc", m1_hready, 1);
        nxt(); drv(0, 32'h0, 1'b0); drv(1, 32'h0, 1'b0); m0_hwdata = 32'h11223344;
        @(negedge clk); chk("t2_m1_hready_pend", m1_hready, 0);
        nxt(); m0_hwdata = '0; s_hrdata = 32'hCAFE0001;
        @(negedge clk); chk("t2_m1_hready_back", m1_hready, 1);
        nxt(); s_hrdata = '0;

        // Round-robin back-to-back contention
        do_reset();
        c = cyc;
        for (int k = 0; k < 8; k++) begin
            drv(0, RR_M0[k], 1'b0); drv(1, RR_M1[k], 1'b0);
            s_hrdata = 32'hD000_0000 | k;
            if (RR_EX[k] != 0)
                exp_x(c + k, c + k + 1, int'(RR_MST[k]), RR_EX[k], 1'b0, 0,
                      32'hD000_0000 | (k + 1), 1'b0, 1);
            nxt();
        end
        drv(0, 32'h0, 1'b0); drv(1, 32'h0, 1'b0); s_hrdata = '0;

        // Fixed priority instance: m1 only served once m0 goes idle
        do_reset();
        for (int k = 0; k < 6; k++) begin
            fdrv(F_M0[k], F_M1[k]);
            @(negedge clk);
            chk("fx_htrans", f_s_htrans, (F_EX[k] != 0) ? 2'b10 : 2'b00);
            if (F_EX[k] != 0) chk("fx_haddr", f_s_haddr, F_EX[k]);
            chk("fx_m1_hready", f_m1_hready, F_HR1[k]);
            chk("fx_m0_hready", f_m0_hready, 1);
            nxt();
        end
        fdrv(32'h0, 32'h0);

        // Two slave wait states in m1 data phase while m0 requests
        do_reset();
        c = cyc;
        drv(1, 32'h3000, 1'b0);
        exp_x(c, c + 3, 1, 32'h3000, 1'b0, 0, 32'hBEEF0003, 1'b0, 1);
        exp_x(c + 3, c + 4, 0, 32'h4000, 1'b0, 0, 32'hBEEF0004, 1'b0, 1);
        nxt(); drv(1, 32'h0, 1'b0); drv(0, 32'h4000, 1'b0); s_hready = 1'b0;
        @(negedge clk);
        chk("t4_w1_htrans", s_htrans, 0);
        chk("t4_w1_m1_hready", m1_hready, 0);
        chk("t4_w1_m0_hready", m0_hready, 1);
        nxt(); drv(0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t4_w2_htrans", s_htrans, 0);
        chk("t4_w2_m0_hready", m0_hready, 0);
        chk("t4_w2_m1_hready", m1_hready, 0);
        nxt(); s_hready = 1'b1; s_hrdata = 32'hBEEF0003;
        @(negedge clk);
        chk("t4_rel_m1_hready", m1_hready, 1);
        chk("t4_rel_m0_hready", m0_hready, 0);
        nxt(); s_hrdata = 32'hBEEF0004;
        @(negedge clk); chk("t4_m0_done", m0_hready, 1);
        nxt(); s_hrdata = '0;

        // Error response in m0 data phase
        c = cyc;
        drv(0, 32'h500, 1'b0);
        exp_x(c, c + 1, 0, 32'h500, 1'b0, 0, 32'h55, 1'b1, 1);
        nxt(); drv(0, 32'h0, 1'b0); s_hresp = 1'b1; s_hrdata = 32'h55;
        @(negedge clk);
        chk("t5_m0_hresp", m0_hresp, 1);
        chk("t5_m1_hresp", m1_hresp, 0);
        nxt(); s_hresp = 1'b0; s_hrdata = '0;

        // Asynchronous reset while m1 is pending
        do_reset();
        c = cyc;
        drv(0, 32'h600, 1'b0); drv(1, 32'h700, 1'b0);
        exp_x(c, c + 1, 0, 32'h600, 1'b0, 0, 0, 1'b0, 0);
        @(negedge clk); chk("t6_m1_acc", m1_hready, 1);
        nxt(); drv(0, 32'h0, 1'b0); drv(1, 32'h0, 1'b0); s_hready = 1'b0;
        @(negedge clk);
        chk("t6_m1_pend", m1_hready, 0);
        chk("t6_wait_htrans", s_htrans, 0);
        #1 s_hready = 1'b1;
        #1 chk("t6_pre_rst_htrans", s_htrans, 2'b10);
        #1 rst_b = 1'b0;
        #1;
        chk("t6_rst_m0_hready", m0_hready, 1);
        chk("t6_rst_m1_hready", m1_hready, 1);
        chk("t6_rst_htrans", s_htrans, 0);
        nxt(); nxt();
        rst_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("t6_no_stale", s_htrans, 0);
            nxt();
        end

        chk("aq_drained", aq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
